// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory access controller: FSM state
// encoding, grant identifiers, bus widths, wait-cycle bounds and the
// fetch/load-store arbitration rule.
package cpu_mem_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Which requester owns the current transaction
    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_LS    = 1'b1
    } grant_t;

    // Legal range of memory access cycles per transaction
    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    // Wait counter only ever holds WAIT_CYCLES-1, so 4 bits cover WAIT_MAX
    localparam int CNT_W  = 4;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    // Force a wait-cycle parameter into the legal range so an out-of-range
    // value can never produce a zero-length or wrapped access window.
    function automatic int clamp_wait(input int wait_cycles);
        if (wait_cycles < WAIT_MIN) begin
            return WAIT_MIN;
        end
        if (wait_cycles > WAIT_MAX) begin
            return WAIT_MAX;
        end
        return wait_cycles;
    endfunction

    // Pick the winner among pending requests. A lone requester always wins.
    // With both pending, load/store has priority unless it won last time,
    // which makes continuous contention alternate between the two.
    function automatic grant_t arbitrate(
        input logic   fetch_req,
        input logic   ls_req,
        input grant_t last_grant
    );
        grant_t winner;
        winner = GRANT_FETCH;
        if (fetch_req && ls_req) begin
            if (last_grant == GRANT_LS) begin
                winner = GRANT_FETCH;
            end else begin
                winner = GRANT_LS;
            end
        end else if (ls_req) begin
            winner = GRANT_LS;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times the ACCESS phase of a memory transaction.
// It is loaded with the number of remaining access cycles, decrements once
// per enabled edge, stops at zero and flags when it has reached zero.
module mem_wait_counter
    import cpu_mem_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Count register: load takes priority over decrement, and it saturates at zero
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller shared by instruction fetch and load/store.
// Each transaction runs IDLE -> ADDR -> ACCESS (WAIT_CYCLES cycles with a
// strobe held) -> DONE (one-cycle completion pulse) -> IDLE. Address, store
// data and direction are captured at grant time, so requesters may change
// their inputs once the transaction is under way.
module mem_access_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        fetch_req,
    input  logic [8:0]  fetch_addr,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [8:0]  ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [31:0] mem_rdata,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] rdata,
    output logic        fetch_done,
    output logic        ls_done,
    output logic        busy
);

    // Counter is loaded with WAIT_CYCLES-1: the edge that sees zero is the
    // last ACCESS edge, giving exactly WAIT_CYCLES strobe cycles.
    localparam int              WAIT_EFF   = clamp_wait(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(WAIT_EFF - 1);

    state_t state;
    state_t state_next;

    grant_t grantee;      // owner of the transaction in flight
    grant_t last_grant;   // owner of the most recent grant, for alternation
    grant_t winner;       // arbitration result for the current IDLE cycle
    logic   store_q;      // captured direction: 1 = store

    logic   take_grant;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;
    logic   capture_read;

    assign winner = arbitrate(fetch_req, ls_req, last_grant);

    // State register; clear aborts any transaction without a done pulse
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter control and output strobes derived from the state
    // NOTE: every signal gets a default at the top of this block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        take_grant   = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        capture_read = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        fetch_done   = 1'b0;
        ls_done      = 1'b0;
        busy         = 1'b1;

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (fetch_req || ls_req) begin
                    take_grant = 1'b1;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                cnt_load   = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_rd = !store_q;
                mem_wr = store_q;
                if (cnt_zero) begin
                    capture_read = !store_q;
                    state_next   = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                fetch_done = (grantee == GRANT_FETCH);
                ls_done    = (grantee == GRANT_LS);
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Grant capture: owner, direction, address and store data frozen at grant
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            grantee    <= GRANT_FETCH;
            last_grant <= GRANT_FETCH;
            store_q    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (take_grant) begin
            grantee    <= winner;
            last_grant <= winner;
            if (winner == GRANT_LS) begin
                store_q   <= ls_we;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
            end else begin
                store_q   <= 1'b0;
                mem_addr  <= fetch_addr;
            end
        end
    end

    // Read data capture on the final ACCESS edge of a load or fetch
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            rdata <= '0;
        end else if (capture_read) begin
            rdata <= mem_rdata;
        end
    end

    mem_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clock      (clock),
        .clear      (clear),
        .load       (cnt_load),
        .load_value (LOAD_VALUE),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. A table of single transactions
// runs on a WAIT_CYCLES=2 instance; hand-written sequences cover reset,
// arbitration alternation, clear mid-access, and the WAIT_CYCLES extremes
// on two extra instances (1 and 15).
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic        fetch_req;
    logic [8:0]  fetch_addr;
    logic        ls_req;
    logic        ls_we;
    logic [8:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] mem_rdata;

    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd, mem_wr;
    logic [31:0] rdata;
    logic        fetch_done, ls_done, busy;

    logic        tie0 = 1'b0;
    logic        fetch_req_w1, fetch_req_w15;
    logic [8:0]  mem_addr_w1, mem_addr_w15;
    logic [31:0] mem_wdata_w1, mem_wdata_w15;
    logic        mem_rd_w1, mem_wr_w1, mem_rd_w15, mem_wr_w15;
    logic [31:0] rdata_w1, rdata_w15;
    logic        fetch_done_w1, ls_done_w1, busy_w1;
    logic        fetch_done_w15, ls_done_w15, busy_w15;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    mem_access_ctrl #(.WAIT_CYCLES(2)) dut (
        .clock(clock), .clear(clear),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .rdata(rdata),
        .fetch_done(fetch_done), .ls_done(ls_done), .busy(busy)
    );

    mem_access_ctrl #(.WAIT_CYCLES(1)) dut_w1 (
        .clock(clock), .clear(clear),
        .fetch_req(fetch_req_w1), .fetch_addr(fetch_addr),
        .ls_req(tie0), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr_w1), .mem_wdata(mem_wdata_w1),
        .mem_rd(mem_rd_w1), .mem_wr(mem_wr_w1), .rdata(rdata_w1),
        .fetch_done(fetch_done_w1), .ls_done(ls_done_w1), .busy(busy_w1)
    );

    mem_access_ctrl #(.WAIT_CYCLES(15)) dut_w15 (
        .clock(clock), .clear(clear),
        .fetch_req(fetch_req_w15), .fetch_addr(fetch_addr),
        .ls_req(tie0), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr_w15), .mem_wdata(mem_wdata_w15),
        .mem_rd(mem_rd_w15), .mem_wr(mem_wr_w15), .rdata(rdata_w15),
        .fetch_done(fetch_done_w15), .ls_done(ls_done_w15), .busy(busy_w15)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        f_req;
        logic [8:0]  f_addr;
        logic        l_req;
        logic        l_we;
        logic [8:0]  l_addr;
        logic [31:0] l_wdata;
        logic [31:0] rd_data;
        logic        scramble;   // disturb addr/data/we once ACCESS starts
        logic        exp_ls;     // 1 = ls granted, 0 = fetch granted
        logic [8:0]  exp_addr;
        logic        exp_wr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs[NVEC];

    // One transaction on the WAIT_CYCLES=2 instance, watched cycle by cycle
    task automatic run_vec(input vec_t v, input int idx);
        int   n = 0;
        int   strobes = 0;
        int   done_at = 0;
        logic saw_fetch = 1'b0;
        logic saw_ls = 1'b0;
        logic rd_seen = 1'b0;
        logic wr_seen = 1'b0;
        logic overlap = 1'b0;
        logic addr_ok = 1'b1;
        logic wdata_ok = 1'b1;
        @(negedge clock);
        fetch_req  = v.f_req;
        fetch_addr = v.f_addr;
        ls_req     = v.l_req;
        ls_we      = v.l_we;
        ls_addr    = v.l_addr;
        ls_wdata   = v.l_wdata;
        mem_rdata  = v.rd_data;
        while (done_at == 0 && n < 40) begin
            @(negedge clock);
            n++;
            if (mem_rd && mem_wr) overlap = 1'b1;
            if (mem_rd || mem_wr) begin
                strobes++;
                rd_seen |= mem_rd;
                wr_seen |= mem_wr;
                if (mem_addr !== v.exp_addr) addr_ok = 1'b0;
                if (v.exp_wr && mem_wdata !== v.exp_wdata) wdata_ok = 1'b0;
                if (v.scramble) begin
                    fetch_addr = ~v.f_addr;
                    ls_addr    = ~v.l_addr;
                    ls_wdata   = ~v.l_wdata;
                    ls_we      = ~v.l_we;
                end
            end
            if (fetch_done || ls_done) begin
                done_at   = n;
                saw_fetch = fetch_done;
                saw_ls    = ls_done;
                fetch_req = 1'b0;
                ls_req    = 1'b0;
            end
        end
        fetch_req = 1'b0;
        ls_req    = 1'b0;
        check($sformatf("v%0d latency", idx), done_at, 4);
        check($sformatf("v%0d strobe_width", idx), strobes, 2);
        check($sformatf("v%0d mem_wr_seen", idx), wr_seen, v.exp_wr);
        check($sformatf("v%0d mem_rd_seen", idx), rd_seen, !v.exp_wr);
        check($sformatf("v%0d strobe_overlap", idx), overlap, 0);
        check($sformatf("v%0d mem_addr", idx), addr_ok, 1);
        check($sformatf("v%0d mem_wdata", idx), wdata_ok, 1);
        check($sformatf("v%0d ls_done", idx), saw_ls, v.exp_ls);
        check($sformatf("v%0d fetch_done", idx), saw_fetch, !v.exp_ls);
        check($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        @(negedge clock);
        check($sformatf("v%0d idle_after", idx), busy, 0);
    endtask

    initial begin
        int   n;
        int   dones;
        int   grant_cnt;
        int   grant_time[4];
        logic grant_ls[4];
        int   str_w1, str_w15, done_w1, done_w15;

        //                f_req f_addr  l_req we  l_addr  l_wdata       rd_data       scr  ls  exp_addr wr  exp_wdata     exp_rdata
        vecs[0] = '{1'b1, 9'h012, 1'b0, 1'b0, 9'h000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 9'h012, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'h55555555, 1'b0, 1'b1, 9'h1FF, 1'b1, 32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h0A5, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1, 9'h0A5, 1'b0, 32'h0,        32'hCAFEF00D};
        vecs[3] = '{1'b1, 9'h100, 1'b1, 1'b1, 9'h033, 32'hA5A5A5A5, 32'h11112222, 1'b0, 1'b0, 9'h100, 1'b0, 32'h0,        32'h11112222};
        vecs[4] = '{1'b1, 9'h100, 1'b1, 1'b1, 9'h033, 32'hA5A5A5A5, 32'h33334444, 1'b0, 1'b1, 9'h033, 1'b1, 32'hA5A5A5A5, 32'h11112222};
        vecs[5] = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h055, 32'h0BADF00D, 32'h0,        1'b1, 1'b1, 9'h055, 1'b1, 32'h0BADF00D, 32'h11112222};
        vecs[6] = '{1'b1, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        32'hFFFFFFFF};

        clear = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_rdata = '0;
        fetch_req_w1 = 1'b0; fetch_req_w15 = 1'b0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("reset busy", busy, 0);
        check("reset strobes", {mem_rd, mem_wr}, 0);
        check("reset dones", {fetch_done, ls_done}, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset rdata", rdata, 0);
        clear = 1'b0;

        // Table of single transactions
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Clear during the second ACCESS cycle of a load
        @(negedge clock);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 9'h0AA; mem_rdata = 32'h13572468;
        @(negedge clock);
        check("clr addr_phase_busy", busy, 1);
        check("clr addr_phase_no_strobe", {mem_rd, mem_wr}, 0);
        @(negedge clock);
        @(negedge clock);
        check("clr second_access_rd", mem_rd, 1);
        clear = 1'b1;
        #1;
        check("clr strobes_drop", {mem_rd, mem_wr}, 0);
        check("clr busy", busy, 0);
        check("clr rdata", rdata, 0);
        check("clr mem_addr", mem_addr, 0);
        check("clr no_done", {fetch_done, ls_done}, 0);
        ls_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (fetch_done || ls_done) dones++;
        end
        check("clr no_done_after", dones, 0);

        // Both requests held: grants alternate starting with ls after clear
        fetch_addr = 9'h010; ls_addr = 9'h020; ls_we = 1'b0;
        fetch_req = 1'b1; ls_req = 1'b1;
        grant_cnt = 0;
        n = 0;
        while (grant_cnt < 4 && n < 60) begin
            @(negedge clock);
            n++;
            if (fetch_done || ls_done) begin
                grant_ls[grant_cnt]   = ls_done;
                grant_time[grant_cnt] = n;
                grant_cnt++;
            end
        end
        fetch_req = 1'b0; ls_req = 1'b0;
        check("alt grant_count", grant_cnt, 4);
        if (grant_cnt == 4) begin
            check("alt grant0_ls", grant_ls[0], 1);
            check("alt grant1_fetch", grant_ls[1], 0);
            check("alt grant2_ls", grant_ls[2], 1);
            check("alt grant3_fetch", grant_ls[3], 0);
            for (int k = 1; k < 4; k++) begin
                check($sformatf("alt spacing%0d", k), grant_time[k] - grant_time[k-1], 5);
            end
        end
        @(negedge clock);
        @(negedge clock);

        // WAIT_CYCLES extremes on the 1- and 15-cycle instances
        fetch_addr = 9'h0F0; mem_rdata = 32'h2468ACE0;
        fetch_req_w1 = 1'b1; fetch_req_w15 = 1'b1;
        str_w1 = 0; str_w15 = 0; done_w1 = 0; done_w15 = 0;
        n = 0;
        while ((done_w1 == 0 || done_w15 == 0) && n < 40) begin
            @(negedge clock);
            n++;
            if (mem_rd_w1) str_w1++;
            if (mem_rd_w15) str_w15++;
            if (fetch_done_w1 && done_w1 == 0) begin
                done_w1 = n;
                fetch_req_w1 = 1'b0;
            end
            if (fetch_done_w15 && done_w15 == 0) begin
                done_w15 = n;
                fetch_req_w15 = 1'b0;
            end
        end
        fetch_req_w1 = 1'b0; fetch_req_w15 = 1'b0;
        check("w1 strobe_width", str_w1, 1);
        check("w1 latency", done_w1, 3);
        check("w1 rdata", rdata_w1, 32'h2468ACE0);
        check("w15 strobe_width", str_w15, 15);
        check("w15 latency", done_w15, 17);
        check("w15 rdata", rdata_w15, 32'h2468ACE0);
        check("w15 mem_addr", mem_addr_w15, 9'h0F0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, memory access cycles with mem_rd/mem_wr held (legal 1..15).
REQ-002 SHALL have port clock  input  1  single rising-edge clock.
REQ-003 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port fetch_req  input  1  instruction-fetch request, level, held until fetch_done.
REQ-005 SHALL have port fetch_addr  input  9  fetch word address.
REQ-006 SHALL have port ls_req  input  1  load/store request, level, held until ls_done.
REQ-007 SHALL have port ls_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port ls_addr  input  9  load/store word address.
REQ-009 SHALL have port ls_wdata  input  32  store data.
REQ-010 SHALL have port mem_rdata  input  32  memory read data, valid in last ACCESS cycle.
REQ-011 SHALL have port mem_addr  output  9  registered memory address.
REQ-012 SHALL have port mem_wdata  output  32  registered store data.
REQ-013 SHALL have port mem_rd / mem_wr  output  1 each  memory strobes.
REQ-014 SHALL have port rdata  output  32  captured read data, held until next read capture.
REQ-015 SHALL have port fetch_done / ls_done  output  1 each  one-cycle completion pulses.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, ADDR, ACCESS, DONE.
REQ-018 IDLE: on edge with any request -> ADDR; latch grantee, address into mem_addr, ls_we, ls_wdata into mem_wdata (fetch: we=0).
REQ-019 Arbitration: single requester wins; both pending -> ls wins unless last grant was ls, then fetch wins (alternation; last_grant bit updated on every grant).
REQ-020 ADDR: one cycle, no strobes; next edge -> ACCESS with wait counter = WAIT_CYCLES-1.
REQ-021 ACCESS: mem_rd (load/fetch) or mem_wr (store) high every cycle; counter decrements per edge; edge with counter==0 -> DONE.
REQ-022 On ACCESS->DONE edge of a read, rdata SHALL capture mem_rdata; stores leave rdata unchanged.
REQ-023 DONE: exactly one of fetch_done/ls_done high for this cycle only, per grantee; next edge -> IDLE unconditionally.
REQ-024 Latency: request sampled at edge 0 -> DONE entered at edge WAIT_CYCLES+1 (WAIT_CYCLES=2: done high after edge 3).
REQ-025 Requests sampled only in IDLE; changes to addr/data/we after grant SHALL be ignored.
REQ-026 A request still high in IDLE after its done SHALL be treated as a new request.
REQ-027 mem_rd and mem_wr SHALL never be high simultaneously nor outside ACCESS.
REQ-028 Back-to-back: minimum spacing between grants is WAIT_CYCLES+3 cycles.

Reset
REQ-029 clear high SHALL immediately force IDLE, strobes/done/busy 0, mem_addr 0, mem_wdata 0, rdata 0, counter 0, last_grant = fetch.
REQ-030 clear mid-transaction SHALL abort with no done pulse; requesters re-issue.

Structure
REQ-031 State encoding and WAIT_CYCLES bounds SHALL live in shared package cpu_mem_pkg.
REQ-032 Wait counter SHALL be sub-module mem_wait_counter (load, decrement, zero flag, async clear).

Verification
REQ-033 Fetch load: fetch_req, fetch_addr=0x012, mem_rdata=0xDEADBEEF -> mem_rd high 2 cycles, fetch_done after edge 3, rdata=0xDEADBEEF.
REQ-034 Store: ls_we=1, ls_addr=0x1FF, ls_wdata=0x12345678 -> mem_wr high 2 cycles, mem_addr=0x1FF, ls_done once, rdata unchanged.
REQ-035 Both requests held continuously -> grants alternate ls, fetch, ls, fetch.
REQ-036 clear asserted in second ACCESS cycle -> strobes drop same cycle, no done, state IDLE, rdata=0.
REQ-037 WAIT_CYCLES=1 and 15 -> strobe width 1 and 15 cycles; done after edge 2 and 16.
REQ-038 Address/data changed during ACCESS -> mem_addr/mem_wdata keep granted values.
